fft64_frame_unpacker: RTL and testbench
=======================================

// Module: fft64_frame_unpacker
// PURPOSE
//  Stream-side counterpart of the 64-point butterfly datapath: captures one 2176-bit parallel
//  output frame (64 x 34-bit complex samples) and serialises it, one sample per accepted beat,
//  on a valid/ready stream. Sits between the butterfly64 output bus and the result sink
//  (output FIFO, file-dump monitor, downstream stage).
//  Frame acceptance overlaps the final beat, so frames stream back-to-back with no bubble.
// PARAMETERS
//  N      64  samples per frame (power of 2)
//  W      34  bits per sample: [W-1:W/2] real, [W/2-1:0] imag, two's complement
//  IDX_W   6  log2(N), width of the sample index
//  CNT_W  16  width of the frames-completed counter
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  frame_in      in   N*W    sample k at bits [W*k+W-1 : W*k]; sample 0 in the LSBs
//  frame_valid   in   1      frame_in holds a complete frame
//  frame_ready   out  1      frame is captured on the edge where frame_valid & frame_ready
//  sample_out    out  W      current sample
//  sample_idx    out  IDX_W  index of sample_out within its frame
//  sample_valid  out  1      sample_out/sample_idx/sample_last are valid
//  sample_ready  in   1      sink accepts the beat when sample_valid & sample_ready
//  sample_last   out  1      high on the beat carrying the final sample of the frame
//  frame_count   out  CNT_W  number of frames fully emitted, modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async, high): state=IDLE, buffer=0, cnt=0, frame_count=0, sample_valid=0,
//   sample_last=0, sample_out=0, sample_idx=0, frame_ready=0 while rst is high.
//  Internal state: N*W holding buffer, IDX_W beat counter cnt, FSM {IDLE, STREAM}.
//  frame_ready = !rst & ((state==IDLE) | (sample_valid & sample_ready & sample_last)).
//   This is combinational from sample_ready. No other input-to-output path exists.
//  IDLE: sample_valid=0. On frame_valid & frame_ready: buffer<=frame_in, cnt<=0, ->STREAM.
//  STREAM: sample_valid=1; sample_idx=addr(cnt); sample_out=buffer[addr(cnt)] (mux of
//   registers); sample_last=(cnt==N-1).
//  Latency: frame captured at edge T -> sample 0 is valid in the cycle after T (T+1).
//  Stall: while sample_valid & !sample_ready, all stream outputs hold stable.
//  Beat accepted with cnt<N-1: cnt<=cnt+1.
//  Beat accepted with cnt==N-1: frame_count<=frame_count+1 (wraps 2^CNT_W-1 -> 0).
//   Then, if frame_valid is high in the same cycle: capture the new frame, cnt<=0, stay in
//   STREAM (no bubble). Otherwise go to IDLE.
//  frame_valid while in STREAM and not on the last beat: ignored, since frame_ready=0;
//   the source must hold the frame.
//  frame_in is sampled only on the capture edge; later changes do not affect the buffer.
//  rst asserted mid-frame: the frame is discarded immediately and sample_valid drops
//   asynchronously. No partial-frame resume; frame_count is cleared.
//  cnt wraps only through the capture/IDLE rules above; it never exceeds N-1.
// CONFIGURATION
//  `define FFT_BITREV_OUT_EN
//   defined:   addr(cnt) = bit-reverse of cnt over IDX_W bits, so the stream is emitted in
//              bit-reversed buffer order (corrects natural/bit-reversed FFT ordering).
//              sample_idx reports the buffer position, e.g. beat 1 -> idx 32.
//   undefined: addr(cnt) = cnt, natural order; sample_idx == beat number.
//  frame_ready, sample_last, frame_count and latency are identical in both builds.
// TESTING
//  1 Reset: hold rst for 3 cycles mid-stream -> sample_valid=0, frame_count=0, frame_ready=0
//    during rst and frame_ready=1 on the first cycle after release.
//  2 Natural order: frame sample k = {17'(k), 17'(-k)}, sample_ready=1 -> 64 beats,
//    beat k: sample_out=frame sample k, idx=k; sample_last only on beat 63;
//    frame_count 0->1; sample 0 valid in the cycle after capture.
//  3 Back-pressure: toggle sample_ready 1,0,0,1 repeatedly -> outputs stable while stalled;
//    exactly 64 accepted beats with no loss or duplication.
//  4 Back-to-back: frame_valid held high with frames A then B -> B is captured on A's last
//    beat; B sample 0 is on the next cycle; no idle cycle; frame_count=2.
//  5 Ignore and wrap: frame_valid pulsed at beat 10 -> not captured, current frame unchanged.
//    Preload frame_count to 16'hFFFF via 65535 frames or force -> next frame gives 0.
//  6 FFT_BITREV_OUT_EN defined, scenario 2 stimulus -> beat 1: idx=32; beat 2: idx=16;
//    beat 63: idx=63; sample_out = buffer[idx].

Source files
------------

// File: rtl/fft64_frame_unpacker_if.sv
// Frame-in / sample-out bus of the 64-point frame unpacker.
// slave is the unpacker side, master is the frame source plus sample sink.
interface fft64_frame_unpacker_if #(
    parameter int N     = 64,
    parameter int W     = 34,
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
);
    logic [N*W-1:0]   frame_in;
    logic             frame_valid;
    logic             frame_ready;
    logic [W-1:0]     sample_out;
    logic [IDX_W-1:0] sample_idx;
    logic             sample_valid;
    logic             sample_ready;
    logic             sample_last;
    logic [CNT_W-1:0] frame_count;

    modport slave (
        input  frame_in, frame_valid, sample_ready,
        output frame_ready, sample_out, sample_idx, sample_valid, sample_last, frame_count
    );

    modport master (
        output frame_in, frame_valid, sample_ready,
        input  frame_ready, sample_out, sample_idx, sample_valid, sample_last, frame_count
    );
endinterface

// File: rtl/fft64_frame_unpacker.sv
// Captures a 64 x 34-bit parallel FFT frame and serialises it one sample per accepted beat.
// Define FFT_BITREV_OUT_EN to emit the buffer in bit-reversed order instead of natural order.
module fft64_frame_unpacker #(
    parameter int N     = 64,
    parameter int W     = 34,
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fft64_frame_unpacker_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state_p0;
    state_t           state_nxt;
    logic [W-1:0]     buf_p0 [N];
    logic [IDX_W-1:0] cnt_p0;
    logic [CNT_W-1:0] frame_count_p0;
    logic [IDX_W-1:0] addr;

    logic             vld;
    logic             last;
    logic             rdy;
    logic [W-1:0]     dout;
    logic [IDX_W-1:0] idx;
    logic             capture;
    logic             accept;

`ifdef FFT_BITREV_OUT_EN
    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = v[IDX_W-1-i];
        end
        return r;
    endfunction

    assign addr = bitrev(cnt_p0);
`else
    assign addr = cnt_p0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // frame_ready reopens on the accepted final beat so the next frame follows with no bubble
    always_comb begin
        state_nxt = state_p0;
        vld       = 1'b0;
        last      = 1'b0;
        rdy       = 1'b0;
        dout      = '0;
        idx       = '0;
        case (state_p0)
            IDLE: begin
                rdy = !rst;
                if (bus.frame_valid && !rst) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                vld  = 1'b1;
                idx  = addr;
                dout = buf_p0[addr];
                last = (cnt_p0 == LAST_IDX);
                if (bus.sample_ready && last) begin
                    rdy       = !rst;
                    state_nxt = bus.frame_valid ? STREAM : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign capture = bus.frame_valid & rdy;
    assign accept  = vld & bus.sample_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0         <= '0;
            frame_count_p0 <= '0;
            for (int k = 0; k < N; k++) begin
                buf_p0[k] <= '0;
            end
        end else begin
            if (capture) begin
                for (int k = 0; k < N; k++) begin
                    buf_p0[k] <= bus.frame_in[W*k +: W];
                end
                cnt_p0 <= '0;
            end else if (accept) begin
                cnt_p0 <= last ? '0 : cnt_p0 + 1'b1;
            end
            if (accept && last) begin
                frame_count_p0 <= frame_count_p0 + 1'b1;
            end
        end
    end

    assign bus.frame_ready  = rdy;
    assign bus.sample_valid = vld;
    assign bus.sample_last  = last;
    assign bus.sample_out   = dout;
    assign bus.sample_idx   = idx;
    assign bus.frame_count  = frame_count_p0;
endmodule

// File: tb/tb_fft64_frame_unpacker.sv
// Directed bench for fft64_frame_unpacker: ordering, stalls, back-to-back frames, wrap, reset.
// A second instance with a 3-bit frame counter shares the stimulus to exercise counter wrap.
module tb_fft64_frame_unpacker;
    localparam int N     = 64;
    localparam int W     = 34;
    localparam int IDX_W = 6;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    fft64_frame_unpacker_if #(.N(N), .W(W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();
    fft64_frame_unpacker_if #(.N(N), .W(W), .IDX_W(IDX_W), .CNT_W(3))     bus_s ();

    fft64_frame_unpacker #(.N(N), .W(W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    fft64_frame_unpacker #(.N(N), .W(W), .IDX_W(IDX_W), .CNT_W(3)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    assign bus_s.frame_in     = bus.frame_in;
    assign bus_s.frame_valid  = bus.frame_valid;
    assign bus_s.sample_ready = bus.sample_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] samp(input int seed, input int j);
        logic [16:0] re;
        logic [16:0] im;
        re = 17'(seed + j);
        im = 17'(-(seed + j));
        return {re, im};
    endfunction

    function automatic logic [N*W-1:0] mkframe(input int seed);
        logic [N*W-1:0] f;
        for (int j = 0; j < N; j++) begin
            f[W*j +: W] = samp(seed, j);
        end
        return f;
    endfunction

    function automatic int exp_addr(input int k);
        int r;
        r = k;
`ifdef FFT_BITREV_OUT_EN
        r = 0;
        for (int i = 0; i < IDX_W; i++) begin
            if (k[i]) r = r | (1 << (IDX_W - 1 - i));
        end
`endif
        return r;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after the capture edge
    task automatic load(input int seed);
        bus.frame_in     = mkframe(seed);
        bus.frame_valid  = 1'b1;
        bus.sample_ready = 1'b1;
        #1;
        check("load_frame_ready", bus.frame_ready, 1);
        check("load_idle_valid", bus.sample_valid, 0);
        @(negedge clk);
        bus.frame_valid = 1'b0;
    endtask

    // Consumes beats of the frame built from seed; chain>=0 offers the next frame throughout,
    // pulse>=0 offers a stray frame at that beat, bp toggles sample_ready 1,0,0,1.
    task automatic drain(input int seed, input bit bp, input int chain, input int pulse,
                         input int stop);
        int           acc;
        int           c;
        bit           stalled;
        bit           rdy;
        logic [W-1:0] prev;
        acc     = 0;
        c       = 0;
        stalled = 1'b0;
        prev    = '0;
        if (chain >= 0) begin
            bus.frame_in    = mkframe(chain);
            bus.frame_valid = 1'b1;
        end
        while (acc < stop && c < 1000) begin
            rdy = bp ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
            bus.sample_ready = rdy;
            if (chain < 0) begin
                bus.frame_valid = (acc == pulse);
                if (acc == pulse) bus.frame_in = mkframe(999);
            end
            #1;
            check("beat_valid", bus.sample_valid, 1);
            check("beat_idx", bus.sample_idx, exp_addr(acc));
            check("beat_data", bus.sample_out, samp(seed, exp_addr(acc)));
            check("beat_last", bus.sample_last, acc == N - 1);
            check("beat_frame_ready", bus.frame_ready, rdy && acc == N - 1);
            if (stalled) check("stall_hold", bus.sample_out, prev);
            stalled = !rdy;
            prev    = bus.sample_out;
            if (rdy) acc++;
            c++;
            @(negedge clk);
        end
        bus.frame_valid = 1'b0;
        check("beats_accepted", acc, stop);
    endtask

    initial begin
        rst              = 1'b1;
        bus.frame_in     = '0;
        bus.frame_valid  = 1'b0;
        bus.sample_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", bus.sample_valid, 0);
        check("rst_frame_ready", bus.frame_ready, 0);
        check("rst_count", bus.frame_count, 0);
        check("rst_out", bus.sample_out, 0);
        check("rst_idx", bus.sample_idx, 0);
        check("rst_last", bus.sample_last, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_frame_ready", bus.frame_ready, 1);
        check("post_rst_valid", bus.sample_valid, 0);
        @(negedge clk);

        // Natural order, full throughput
        load(0);
        drain(0, 1'b0, -1, -1, N);
        #1;
        check("f1_idle_valid", bus.sample_valid, 0);
        check("f1_idle_last", bus.sample_last, 0);
        check("f1_count", bus.frame_count, 1);
        check("f1_frame_ready", bus.frame_ready, 1);
        @(negedge clk);

        // Back-pressure
        load(200);
        drain(200, 1'b1, -1, -1, N);
        #1;
        check("bp_count", bus.frame_count, 2);
        check("bp_idle_valid", bus.sample_valid, 0);
        @(negedge clk);

        // Back-to-back A then B, B offered for the whole of A
        load(300);
        drain(300, 1'b0, 400, -1, N);
        drain(400, 1'b0, -1, -1, N);
        #1;
        check("b2b_count", bus.frame_count, 4);
        @(negedge clk);

        // Stray frame_valid mid-frame is ignored
        load(500);
        drain(500, 1'b0, -1, 10, N);
        #1;
        check("ignore_count", bus.frame_count, 5);
        check("ignore_idle_valid", bus.sample_valid, 0);
        @(negedge clk);

        // Counter wrap on the 3-bit instance: 7 -> 0
        for (int i = 0; i < 2; i++) begin
            load(600 + 10 * i);
            drain(600 + 10 * i, 1'b0, -1, -1, N);
            @(negedge clk);
        end
        #1;
        check("wrap_pre_small", bus_s.frame_count, 7);
        @(negedge clk);
        load(700);
        drain(700, 1'b0, -1, -1, N);
        #1;
        check("wrap_small", bus_s.frame_count, 0);
        check("wrap_full", bus.frame_count, 8);
        @(negedge clk);

        // Reset mid-stream for 3 cycles
        load(800);
        drain(800, 1'b0, -1, -1, 20);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.sample_valid, 0);
        check("mid_rst_frame_ready", bus.frame_ready, 0);
        check("mid_rst_count", bus.frame_count, 0);
        check("mid_rst_small_count", bus_s.frame_count, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("hold_rst_valid", bus.sample_valid, 0);
            check("hold_rst_frame_ready", bus.frame_ready, 0);
            check("hold_rst_count", bus.frame_count, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_frame_ready", bus.frame_ready, 1);
        check("rel_valid", bus.sample_valid, 0);
        @(negedge clk);
        load(900);
        drain(900, 1'b0, -1, -1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
